// File: rtl/lbp_hist.sv
// Reads the 6x6 interior of the 8x8 LBP result memory, bins each code into the
// 10 rotation-invariant uniform (riu2) classes and streams the histogram out.
module lbp_hist (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] rd_addr,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       hist_valid,
  input  logic       hist_ready,
  output logic [3:0] hist_bin,
  output logic [5:0] hist_count,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StOut, StDone} state_e;

  state_e     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic       pend_q;
  logic       clear_bins;
  logic [5:0] bins_q [10];

  logic [7:0] ring;
  logic [7:0] diff;
  logic [3:0] trans;
  logic [3:0] ones;
  logic [3:0] code_bin;

  // Neighbours in circular order TL,T,TR,R,BR,B,BL,L; ring[i] and ring[i+1] are adjacent.
  assign ring = {rd_data[3], rd_data[5], rd_data[6], rd_data[7],
                 rd_data[4], rd_data[2], rd_data[1], rd_data[0]};
  assign diff = ring ^ {ring[0], ring[7:1]};

  always_comb begin
    trans = '0;
    ones  = '0;
    for (int i = 0; i < 8; i++) begin
      trans = trans + 4'(diff[i]);
      ones  = ones + 4'(rd_data[i]);
    end
    code_bin = (trans <= 4'd2) ? ones : 4'd9;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    clear_bins = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRead;
          addr_d     = 6'd9;
          cnt_d      = '0;
          idx_d      = '0;
          clear_bins = 1'b1;
        end
      end
      StRead: begin
        if (cnt_q == 6'd35) begin
          state_d = StDrain;
          addr_d  = '0;
        end else begin
          cnt_d  = cnt_q + 6'd1;
          // Column 6 wraps to column 1 of the next row, skipping two border cells.
          addr_d = (addr_q[2:0] == 3'd6) ? addr_q + 6'd3 : addr_q + 6'd1;
        end
      end
      StDrain: state_d = StOut;
      StOut: begin
        if (hist_ready) begin
          if (idx_q == 4'd9) state_d = StDone;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= rd_req;
    end
  end

  // pend_q marks the cycle in which rd_data carries the previously requested code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) bins_q[i] <= '0;
    end else if (clear_bins) begin
      for (int i = 0; i < 10; i++) bins_q[i] <= '0;
    end else if (pend_q) begin
      for (int i = 0; i < 10; i++) begin
        if (code_bin == 4'(i)) bins_q[i] <= bins_q[i] + 6'd1;
      end
    end
  end

  assign rd_req     = (state_q == StRead);
  assign rd_addr    = addr_q;
  assign hist_valid = (state_q == StOut);
  assign hist_bin   = idx_q;
  assign done       = (state_q == StDone);

  always_comb begin
    hist_count = '0;
    if (hist_valid) begin
      for (int i = 0; i < 10; i++) begin
        if (idx_q == 4'(i)) hist_count = bins_q[i];
      end
    end
  end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed-plus-random bench for lbp_hist: memory model, riu2 reference model,
// handshake and read-address monitors.
module tb_lbp_hist;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] rd_addr;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       hist_valid;
  logic       hist_ready;
  logic [3:0] hist_bin;
  logic [5:0] hist_count;
  logic       done;

  always #5 clk = ~clk;

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rd_addr    (rd_addr),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .done       (done)
  );

  logic [7:0] mem [64];
  int addr_log[$];
  int hs_bin[$];
  int hs_cnt[$];
  int exp_bins[10];
  int total = 0;
  int bad = 0;

  always @(posedge clk) begin
    if (rd_req) rd_data <= mem[rd_addr];
  end

  always @(posedge clk) begin
    if (rd_req) addr_log.push_back(int'(rd_addr));
    if (hist_valid && hist_ready) begin
      hs_bin.push_back(int'(hist_bin));
      hs_cnt.push_back(int'(hist_count));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // riu2 class straight from the definition: walk the neighbour ring, count bit flips.
  function automatic int riu2(input logic [7:0] p);
    int ord[8] = '{0, 1, 2, 4, 7, 6, 5, 3};
    int t = 0;
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      if (p[ord[i]] != p[ord[(i + 1) % 8]]) t++;
      if (p[i]) n++;
    end
    return (t <= 2) ? n : 9;
  endfunction

  task automatic build_model();
    for (int b = 0; b < 10; b++) exp_bins[b] = 0;
    for (int r = 1; r <= 6; r++)
      for (int c = 1; c <= 6; c++) exp_bins[riu2(mem[r * 8 + c])]++;
  endtask

  // kind: 0 border FF/interior 00, 1 all FF, 2 all 55, 3 07/0B/03 mix, else random
  task automatic fill(input int kind);
    int n = 0;
    for (int a = 0; a < 64; a++) begin
      int r = a / 8;
      int c = a % 8;
      bit border = (r == 0) || (r == 7) || (c == 0) || (c == 7);
      if (border) begin
        mem[a] = (kind == 0 || kind == 1) ? 8'hFF : 8'($urandom);
      end else begin
        case (kind)
          0: mem[a] = 8'h00;
          1: mem[a] = 8'hFF;
          2: mem[a] = 8'h55;
          3: mem[a] = (n < 12) ? 8'h07 : (n < 24) ? 8'h0B : 8'h03;
          default: mem[a] = 8'($urandom);
        endcase
        n++;
      end
    end
  endtask

  // Called at a negedge with the DUT idle; start is sampled at the next posedge (E0).
  // Negedge k follows edge E0+k-1.
  task automatic run_pass(input string name, input bit stall);
    int first_valid = -1;
    int done_k = -1;
    int hs_at_done = -1;
    int stall_n = 0;
    int req_bad = 0;
    int stable_bad = 0;
    int seq_bad = 0;
    int exp_addr[$];
    bit prev_st = 1'b0;
    bit tog = 1'b0;
    logic [3:0] pb = '0;
    logic [5:0] pc = '0;
    build_model();
    for (int r = 1; r <= 6; r++)
      for (int c = 1; c <= 6; c++) exp_addr.push_back(r * 8 + c);
    addr_log.delete();
    hs_bin.delete();
    hs_cnt.delete();
    start = 1'b1;
    hist_ready = 1'b1;
    for (int k = 1; k <= 200 && done_k < 0; k++) begin
      @(negedge clk);
      if (rd_req !== (k <= 36)) req_bad++;
      if (k == 1) check({name, " first_addr"}, 32'(rd_addr), 32'd9);
      if (k == 36) check({name, " last_addr"}, 32'(rd_addr), 32'd54);
      if (hist_valid === 1'b1 && first_valid < 0) first_valid = k;
      if (prev_st && (hist_bin !== pb || hist_count !== pc)) stable_bad++;
      if (done === 1'b1 && done_k < 0) begin
        done_k = k;
        hs_at_done = hs_bin.size();
      end
      if (stall) begin
        if (hist_valid && hist_bin == 4'd3 && stall_n < 5) begin
          hist_ready = 1'b0;
          stall_n++;
        end else if (stall_n >= 5) begin
          tog = !tog;
          hist_ready = tog;
        end else begin
          hist_ready = 1'b1;
        end
      end
      prev_st = hist_valid && !hist_ready;
      pb = hist_bin;
      pc = hist_count;
    end
    hist_ready = 1'b1;
    check({name, " done_seen"}, 32'(done_k > 0), 32'd1);
    check({name, " first_valid_cycle"}, 32'(first_valid), 32'd38);
    if (!stall) check({name, " done_cycle"}, 32'(done_k), 32'd48);
    else check({name, " stall_seen"}, 32'(stall_n), 32'd5);
    check({name, " rd_req_window"}, 32'(req_bad), 32'd0);
    check({name, " stall_stable"}, 32'(stable_bad), 32'd0);
    check({name, " hs_at_done"}, 32'(hs_at_done), 32'd10);
    check({name, " addr_count"}, 32'(addr_log.size()), 32'd36);
    for (int i = 0; i < addr_log.size() && i < 36; i++)
      if (addr_log[i] != exp_addr[i]) seq_bad++;
    check({name, " addr_seq"}, 32'(seq_bad), 32'd0);
    check({name, " hs_count"}, 32'(hs_bin.size()), 32'd10);
    for (int i = 0; i < hs_bin.size() && i < 10; i++) begin
      check($sformatf("%s hs_bin%0d", name, i), 32'(hs_bin[i]), 32'(i));
      check($sformatf("%s bin%0d", name, i), 32'(hs_cnt[i]), 32'(exp_bins[i]));
    end
  endtask

  // Start held high after done must not retrigger; dropping it returns to idle.
  task automatic post_pass(input string name);
    int extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b1 || rd_req !== 1'b0) extra++;
    end
    check({name, " done_held"}, 32'(extra), 32'd0);
    check({name, " no_second_pass"}, 32'(addr_log.size()), 32'd36);
    start = 1'b0;
    @(negedge clk);
    check({name, " done_drop"}, 32'(done), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rd_addr"}, 32'(rd_addr), 32'd0);
    check({name, " rd_req"}, 32'(rd_req), 32'd0);
    check({name, " hist_valid"}, 32'(hist_valid), 32'd0);
    check({name, " hist_bin"}, 32'(hist_bin), 32'd0);
    check({name, " hist_count"}, 32'(hist_count), 32'd0);
    check({name, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hist_ready = 1'b1;
    rd_data = '0;
    for (int a = 0; a < 64; a++) mem[a] = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    fill(0); run_pass("zeros", 1'b0); post_pass("zeros");
    fill(1); run_pass("ones", 1'b0); post_pass("ones");
    fill(2); run_pass("x55", 1'b0); post_pass("x55");
    fill(3); run_pass("mix", 1'b0); post_pass("mix");
    fill(4); run_pass("rand1", 1'b0); post_pass("rand1");
    fill(4); run_pass("rand2", 1'b0); post_pass("rand2");
    fill(0); run_pass("stall", 1'b1); post_pass("stall");

    // Abort mid-read at address 30 with start held high throughout.
    fill(4);
    start = 1'b1;
    for (int w = 0; w < 60 && rd_addr !== 6'd30; w++) @(negedge clk);
    check("abort at_addr30", 32'(rd_addr), 32'd30);
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    run_pass("restart", 1'b0);
    post_pass("restart");

    fill(4); run_pass("rand3", 1'b1); post_pass("rand3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lbp_hist.md
# lbp_hist

Downstream stage of the 8x8 LBP engine. Once the LBP pass finishes, the block reads the 36 interior LBP codes from the LBP result memory. It classifies each code as a rotation-invariant uniform pattern (riu2, 10 classes) and accumulates a 10-bin histogram. It then streams the histogram out over a valid/ready interface to the feature/classifier stage.

## Interface
Parameters: none; image is fixed at 8x8 with a 6x6 interior.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  level; driven by the LBP engine's finish
- rd_addr  out  6  LBP memory read address
- rd_req  out  1  read request; memory returns rd_data one cycle after rd_addr/rd_req
- rd_data  in  8  LBP code, valid the cycle after the request
- hist_valid  out  1  histogram entry valid
- hist_ready  in  1  consumer accepts the entry when hist_valid and hist_ready are both high at a clock edge
- hist_bin  out  4  bin index 0..9
- hist_count  out  6  bin count 0..36
- done  out  1  histogram fully transferred

## Operation
- States:
  - IDLE → READ when start=1.
  - READ runs 36 cycles → DRAIN.
  - DRAIN runs 1 cycle → OUT.
  - OUT → DONE after bin 9 is accepted.
  - DONE → IDLE when start=0.
- Entering READ clears all 10 bin counters (6 bits each).
- READ scan:
  - Raster order over rows 1..6, cols 1..6; rd_addr = row*8+col.
  - Sequence is 9..14, 17..22, 25..30, 33..38, 41..46, 49..54.
  - Border addresses are never requested.
  - rd_req=1 in every READ cycle and 0 in every other state.
- Classification of code p, applied to rd_data in the cycle after each request:
  - Circular neighbour order c = {p0,p1,p2,p4,p7,p6,p5,p3} (TL, T, TR, R, BR, B, BL, L).
  - T = number of positions i where c[i] != c[(i+1) mod 8].
  - If T <= 2: bin = popcount(p), giving 0..8. Otherwise bin = 9.
  - The selected bin increments by 1. Max value is 36, so there is no overflow and no saturation logic.
- OUT state:
  - Presents bins in order 0..9; hist_bin = index, hist_count = that counter.
  - hist_valid is held high throughout.
  - The index advances only on a handshake.
- DONE: done=1, hist_valid=0. DONE is held while start stays high, so a still-asserted finish does not retrigger the block.
- start is ignored outside IDLE.

## Timing
- Reset values:
  - rd_addr=0, rd_req=0, hist_valid=0, hist_bin=0, hist_count=0, done=0.
  - All bins are 0 and the state is IDLE.
- Let edge E0 be the edge at which start is sampled in IDLE.
  - Cycle after E0: rd_addr=9, rd_req=1.
  - Last request (addr 54) is in the 36th READ cycle.
  - DRAIN accumulates the final code.
  - hist_valid rises at E0+37 with hist_bin=0.
- With hist_ready held at 1:
  - One bin is transferred per cycle; bin 9 is accepted at edge E0+47.
  - done=1 from E0+47.
- Backpressure: while hist_ready=0, hist_bin and hist_count are held stable. No bin is skipped or repeated.
- Counters are not modified during OUT.
- Reset mid-operation (any state):
  - Immediate abort to the reset values.
  - Partial counts are discarded; no partial histogram is emitted.
  - A subsequent start runs a full fresh pass.

## Test plan
- Interior all 0x00, hist_ready=1 → bin0=36, bins 1..9 = 0. hist_valid first high at E0+37; done at E0+47.
- Interior all 0xFF → bin8=36, all others 0.
- Interior all 0x55 → bin9=36, since c=1,0,1,1,0,1,0,0 gives T=6.
  - Also: 12 codes of 0x07, 12 of 0x0B, 12 of 0x03 → bin3=24, bin2=12. This checks that 0x0B is contiguous in circular order.
- Border addresses hold 0xFF, interior holds 0x00 → bin0=36.
  - Monitor confirms the exact rd_addr sequence 9..54 with no border addresses, and rd_req=0 outside READ.
- Backpressure: with interior of 0x00, hold hist_ready=0 for 5 cycles while bin 3 is presented, then toggle it every cycle.
  - bin/count stay stable while stalled.
  - Exactly 10 handshakes occur, in order 0..9.
  - done is raised only after bin 9 is accepted.
- Assert reset while rd_addr=30 → all outputs return to reset values in the same cycle.
  - Keep start high through reset: a new pass starts and yields the correct full histogram.
  - After done, start stays high → no second pass. Lower start, then raise it → new pass.
